// File: rtl/present_masked_pkg.sv
// Shared definitions for the masked PRESENT substitution/permutation sequencer.
package present_masked_pkg;

   localparam int SBOX_LAT_DEF = 4;
   localparam int NIBBLES_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FEED = 2'd1,
      PERM = 2'd2,
      DONE = 2'd3
   } seq_state_e;

   // PRESENT pLayer destination of source bit i; bit 63 is a fixed point.
   function automatic int player_idx(input int i);
      return (i == 63) ? 63 : (16 * i) % 63;
   endfunction

endpackage

// File: rtl/present_player.sv
// Combinational PRESENT pLayer on one 64-bit share.
module present_player
   import present_masked_pkg::*;
(
   input  logic [63:0] x,
   output logic [63:0] y
);

   for (genvar i = 0; i < 64; i++) begin : g_bit
      assign y[player_idx(i)] = x[i];
   end

endmodule

// File: rtl/present_sbox_sequencer.sv
// Serialises one masked PRESENT sBox layer through an external S-box, then applies
// the pLayer share-wise. Shares live in separate rows of st and never meet.
module present_sbox_sequencer
   import present_masked_pkg::*;
#(
   parameter int SBOX_LAT = SBOX_LAT_DEF,
   parameter int NIBBLES  = NIBBLES_DEF
) (
   input  logic        clock_0,
   input  logic        reset_0,
   input  logic        start,
   input  logic [63:0] state_in_s0,
   input  logic [63:0] state_in_s1,
   input  logic [63:0] rkey_s0,
   input  logic [63:0] rkey_s1,
   output logic [3:0]  sb_i_s0,
   output logic [3:0]  sb_i_s1,
   output logic [3:0]  sb_k_s0,
   output logic [3:0]  sb_k_s1,
   input  logic [3:0]  sb_o_s0,
   input  logic [3:0]  sb_o_s1,
   output logic        busy,
   output logic        done,
   output logic [63:0] state_out_s0,
   output logic [63:0] state_out_s1
);

   localparam int HW = $clog2(SBOX_LAT + 1);
   localparam int NW = $clog2(NIBBLES);

   seq_state_e       state, state_nxt;
   logic [HW-1:0]    h;
   logic [NW-1:0]    n;
   logic [1:0][63:0] st, st_perm, rkey;
   logic             last_hold;

   assign rkey      = {rkey_s1, rkey_s0};
   assign last_hold = (h == HW'(SBOX_LAT));

   for (genvar s = 0; s < 2; s++) begin : g_share
      present_player u_player (
         .x (st[s]),
         .y (st_perm[s])
      );
   end

   always_ff @(posedge clock_0 or negedge reset_0) begin
      if (!reset_0) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FEED;
         FEED:    if (last_hold && n == NW'(NIBBLES - 1)) state_nxt = PERM;
         PERM:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Inputs to the S-box are held for SBOX_LAT+1 cycles; capture on the last one.
   always_ff @(posedge clock_0 or negedge reset_0) begin
      if (!reset_0) begin
         st <= '0;
         n  <= '0;
         h  <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               st[0] <= state_in_s0;
               st[1] <= state_in_s1;
               n     <= '0;
               h     <= '0;
            end
            FEED: if (last_hold) begin
               st[0][4*n +: 4] <= sb_o_s0;
               st[1][4*n +: 4] <= sb_o_s1;
               h               <= '0;
               n               <= n + 1'b1;
            end else begin
               h <= h + 1'b1;
            end
            PERM:    st <= st_perm;
            default: ;
         endcase
      end
   end

   always_comb begin
      busy    = (state != IDLE);
      done    = (state == DONE);
      sb_i_s0 = '0;
      sb_i_s1 = '0;
      sb_k_s0 = '0;
      sb_k_s1 = '0;
      if (state == FEED) begin
         sb_i_s0 = st[0][4*n +: 4];
         sb_i_s1 = st[1][4*n +: 4];
         sb_k_s0 = rkey[0][4*n +: 4];
         sb_k_s1 = rkey[1][4*n +: 4];
      end
   end

   assign state_out_s0 = st[0];
   assign state_out_s1 = st[1];

endmodule

// File: tb/tb_present_sbox_sequencer.sv
// Scoreboard bench: reference masked S-box with fresh masks, unmasked layer model.
module tb_present_sbox_sequencer;

   logic        clock_0 = 1'b0;
   logic        reset_0;
   logic        start;
   logic [63:0] state_in_s0, state_in_s1, rkey_s0, rkey_s1;
   logic [3:0]  sb_i_s0, sb_i_s1, sb_k_s0, sb_k_s1, sb_o_s0, sb_o_s1;
   logic        busy, done;
   logic [63:0] state_out_s0, state_out_s1;

   present_sbox_sequencer dut (
      .clock_0      (clock_0),
      .reset_0      (reset_0),
      .start        (start),
      .state_in_s0  (state_in_s0),
      .state_in_s1  (state_in_s1),
      .rkey_s0      (rkey_s0),
      .rkey_s1      (rkey_s1),
      .sb_i_s0      (sb_i_s0),
      .sb_i_s1      (sb_i_s1),
      .sb_k_s0      (sb_k_s0),
      .sb_k_s1      (sb_k_s1),
      .sb_o_s0      (sb_o_s0),
      .sb_o_s1      (sb_o_s1),
      .busy         (busy),
      .done         (done),
      .state_out_s0 (state_out_s0),
      .state_out_s1 (state_out_s1)
   );

   always #5 clock_0 = ~clock_0;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_ne(input string nm, input logic [63:0] act, input logic [63:0] bad);
      tests++;
      if (act === bad) begin
         fails++;
         $display("FAIL %s: got %h which must differ from %h", nm, act, bad);
      end
   endtask

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   // Unmasked reference: sbox each nibble, add key after the sbox, then pLayer.
   function automatic logic [63:0] ref_layer(input logic [63:0] s0, s1, k0, k1);
      logic [63:0] x, k, y, p;
      x = s0 ^ s1;
      k = k0 ^ k1;
      for (int j = 0; j < 16; j++) y[4*j +: 4] = sbox(x[4*j +: 4]) ^ k[4*j +: 4];
      p = '0;
      for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : 16 * (i % 4) + i / 4] = y[i];
      return p;
   endfunction

   // Reference masked S-box: output is only correct after the inputs have been
   // stable for 4 edges; otherwise it is corrupted. Fresh mask every cycle.
   logic [15:0] hist [4];
   logic [15:0] cur;
   logic [3:0]  rnd, sb_y;
   assign cur = {sb_i_s0, sb_i_s1, sb_k_s0, sb_k_s1};
   always @(posedge clock_0) begin
      hist[0] <= cur;
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
      rnd <= 4'($urandom);
   end
   always_comb begin
      sb_y = sbox(hist[3][15:12] ^ hist[3][11:8]) ^ hist[3][7:4] ^ hist[3][3:0];
      if (hist[0] != cur || hist[1] != cur || hist[2] != cur || hist[3] != cur)
         sb_y = sb_y ^ 4'h5;
   end
   assign sb_o_s0 = sb_y ^ rnd;
   assign sb_o_s1 = rnd;

   typedef struct {
      logic [63:0] s0, s1, k0, k1, exp;
      bit          chk_sh;
   } txn_t;
   txn_t sbq[$];

   int done_cnt = 0;
   int bcnt     = 0;
   bit hold_bad = 0;

   // Monitor: follows each busy window, checks nibble order/hold, scores on done.
   always @(negedge clock_0) begin
      txn_t t;
      int   j;
      if (!reset_0) begin
         bcnt = 0;
      end else if (busy) begin
         bcnt++;
         if (bcnt == 1) hold_bad = 0;
         if (sbq.size() > 0) begin
            if (bcnt <= 80) begin
               j = (bcnt - 1) / 5;
               if (sb_i_s0 !== sbq[0].s0[4*j +: 4] || sb_i_s1 !== sbq[0].s1[4*j +: 4] ||
                   sb_k_s0 !== sbq[0].k0[4*j +: 4] || sb_k_s1 !== sbq[0].k1[4*j +: 4])
                  hold_bad = 1;
            end else if ({sb_i_s0, sb_i_s1, sb_k_s0, sb_k_s1} !== 16'h0) begin
               hold_bad = 1;
            end
         end
         if (done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
               chk("spurious_done", 64'(done), 64'd0);
            end else begin
               t = sbq.pop_front();
               chk("result", state_out_s0 ^ state_out_s1, t.exp);
               chk("latency", 64'(bcnt), 64'd82);
               chk("sbox_hold", 64'(hold_bad), 64'd0);
               if (t.chk_sh) begin
                  chk_ne("share0_masked", state_out_s0, t.exp);
                  chk_ne("share1_masked", state_out_s1, t.exp);
               end
            end
         end
      end else begin
         bcnt = 0;
         if (done) chk("done_outside_busy", 64'(done), 64'd0);
      end
   end

   int          issued = 0;
   logic [63:0] last_exp;

   task automatic run_layer(input logic [63:0] s0, s1, k0, k1, input bit chk_sh, input bit glitch);
      txn_t t;
      int   d0;
      t.s0 = s0; t.s1 = s1; t.k0 = k0; t.k1 = k1; t.chk_sh = chk_sh;
      t.exp = ref_layer(s0, s1, k0, k1);
      last_exp = t.exp;
      @(posedge clock_0); #1;
      state_in_s0 = s0; state_in_s1 = s1; rkey_s0 = k0; rkey_s1 = k1;
      d0 = done_cnt;
      sbq.push_back(t);
      issued++;
      start = 1'b1;
      @(posedge clock_0); #1;
      start = 1'b0;
      if (glitch) begin
         repeat (20) @(posedge clock_0);
         #1;
         state_in_s0 = {$urandom, $urandom};
         state_in_s1 = {$urandom, $urandom};
         start = 1'b1;
         @(posedge clock_0); #1;
         start = 1'b0;
      end
      for (int k = 0; k < 300 && done_cnt == d0; k++) @(posedge clock_0);
      if (done_cnt == d0) chk("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] r, k;
      int          d0;
      reset_0 = 1'b0;
      start   = 1'b0;
      state_in_s0 = '0; state_in_s1 = '0; rkey_s0 = '0; rkey_s1 = '0;
      repeat (3) @(posedge clock_0);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_sb", 64'({sb_i_s0, sb_i_s1, sb_k_s0, sb_k_s1}), 64'd0);
      chk("rst_out0", state_out_s0, 64'd0);
      chk("rst_out1", state_out_s1, 64'd0);
      #2 reset_0 = 1'b1;

      run_layer(64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
      chk("zero_const", last_exp, 64'hFFFFFFFF00000000);

      r = {$urandom, $urandom};
      run_layer(r, r, 64'd0, 64'd0, 1'b1, 1'b0);

      k = {$urandom, $urandom};
      run_layer(64'd0, 64'd0, k, k ^ 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
      chk("key_const", last_exp, 64'h00000000FFFFFFFF);

      for (int i = 0; i < 6; i++)
         run_layer({$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);

      run_layer({$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);

      // Abort mid-layer at nibble 7.
      @(posedge clock_0); #1;
      state_in_s0 = {$urandom, $urandom}; state_in_s1 = {$urandom, $urandom};
      sbq.push_back('{state_in_s0, state_in_s1, rkey_s0, rkey_s1, 64'd0, 1'b0});
      start = 1'b1;
      @(posedge clock_0); #1;
      start = 1'b0;
      repeat (36) @(posedge clock_0);
      #2 reset_0 = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_sb", 64'({sb_i_s0, sb_i_s1, sb_k_s0, sb_k_s1}), 64'd0);
      void'(sbq.pop_front());
      d0 = done_cnt;
      repeat (2) @(posedge clock_0);
      #3 reset_0 = 1'b1;
      repeat (100) @(posedge clock_0);
      #1;
      chk("abort_no_done", 64'(done_cnt), 64'(d0));
      chk("abort_idle", 64'(busy), 64'd0);

      run_layer({$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);

      repeat (5) @(posedge clock_0);
      #1;
      chk("held_out", state_out_s0 ^ state_out_s1, last_exp);
      chk("queue_empty", 64'(sbq.size()), 64'd0);
      chk("done_count", 64'(done_cnt), 64'(issued));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/present_sbox_sequencer.md
PRESENT_SBOX_SEQUENCER -- requirements
Module: present_sbox_sequencer

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 4: clock edges from a stable masked S-box input to a valid masked S-box output.
REQ-002 SHALL have parameter NIBBLES, default 16: number of 4-bit nibbles in the 64-bit state.
REQ-003 SHALL have port clock_0, in, 1: single clock, rising edge.
REQ-004 SHALL have port reset_0, in, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, in, 1: request one substitution-plus-permutation layer.
REQ-006 SHALL have ports state_in_s0 and state_in_s1, in, 64 each: Boolean shares of the input state.
REQ-007 SHALL have ports rkey_s0 and rkey_s1, in, 64 each: round-key shares, held stable by the top level while busy=1.
REQ-008 SHALL have ports sb_i_s0 and sb_i_s1, out, 4 each: masked nibble driven to the external S-box.
REQ-009 SHALL have ports sb_k_s0 and sb_k_s1, out, 4 each: masked key nibble driven to the external S-box.
REQ-010 SHALL have ports sb_o_s0 and sb_o_s1, in, 4 each: masked S-box output with the key nibble already added.
REQ-011 SHALL have port busy, out, 1: high from start acceptance until done.
REQ-012 SHALL have port done, out, 1: one-cycle pulse when the result is valid.
REQ-013 SHALL have ports state_out_s0 and state_out_s1, out, 64 each: result shares, held until the next accepted start.

Function
REQ-014 FSM SHALL have states IDLE, FEED, PERM, DONE.
REQ-015 In IDLE, start=1 SHALL, at the same edge, load both state shares, clear nibble counter n and hold counter h, and go to FEED.
REQ-016 start SHALL be ignored in every state except IDLE.
REQ-017 In FEED, sb_i_sX SHALL equal state_sX[4n+3:4n] and sb_k_sX SHALL equal rkey_sX[4n+3:4n].
REQ-018 In FEED, both outputs SHALL stay constant for SBOX_LAT+1 cycles, because the S-box combines registered and direct input terms.
REQ-019 h SHALL count 0..SBOX_LAT. At the edge where h=SBOX_LAT, sb_o_sX SHALL be written into state_sX nibble n, h SHALL clear, and n SHALL increment.
REQ-020 At the capture edge of nibble NIBBLES-1, the FSM SHALL go to PERM.
REQ-021 PERM SHALL last one cycle and apply the PRESENT pLayer to each share independently: bit i moves to (16*i) mod 63 for i<63, and bit 63 stays fixed.
REQ-022 Shares SHALL never be combined with each other anywhere in the block.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE. Total: done is high in the cycle that follows clock edge number 16*(SBOX_LAT+1)+1 after the start edge, i.e. after edge 81 at default.
REQ-024 busy SHALL be 1 in FEED, PERM and DONE, and 0 in IDLE.
REQ-025 state_out_sX SHALL be driven directly from the state registers; it is valid only while done=1 and afterwards in IDLE.
REQ-026 sb_i_sX and sb_k_sX SHALL be driven to 0 when not in FEED.
REQ-027 The external S-box randomness SHALL be supplied fresh each cycle by the top level; this block does not generate or gate randomness.

Reset
REQ-028 When reset_0=0, the block SHALL asynchronously reset to IDLE, with n=0, h=0, busy=0, done=0, both state shares 0, and all sb_* outputs 0.
REQ-029 A reset asserted mid-layer SHALL abort the operation. After release, the block SHALL wait in IDLE, and a partial result SHALL never produce done.

Structure
REQ-030 A shared package present_masked_pkg SHALL hold: SBOX_LAT and NIBBLES defaults, the FSM state enum, and the pLayer index function.
REQ-031 The block SHALL instantiate a single combinational sub-module, present_player (64-bit permutation), once per share.
REQ-032 The S-box SHALL remain outside this block and SHALL connect via the sb_* ports.

Verification
REQ-033 The bench SHALL connect a reference masked S-box with SBOX_LAT=4 and fresh random bits every cycle.
REQ-034 Zero test: shares 0/0 and key 0/0 -> done after 81 edges, and state_out_s0^state_out_s1 = 0xFFFFFFFF00000000.
REQ-035 Random mask: state shares R/R for random R and key 0/0 -> unmasked result 0xFFFFFFFF00000000, and each output share differs from that value with overwhelming probability.
REQ-036 Key test: state 0 and key shares K/(K^0xFFFFFFFFFFFFFFFF) -> unmasked result 0x00000000FFFFFFFF.
REQ-037 Hold check: sb_i_sX and sb_k_sX stay constant for 5 consecutive cycles per nibble, with nibble 0 first and nibble 15 last.
REQ-038 Robustness: a start pulse during FEED is ignored and the result is unchanged.
REQ-039 Reset check: reset_0 pulsed low at nibble 7 -> immediate IDLE with busy=0 and done=0 and no done pulse, and a subsequent start completes normally.
